// File: rtl/axis_tile_reorder.sv
// Reorders BLK x BLK tile-order pixels into raster-order AXI-Stream through NBUF band buffers.
// Define AXIS_TILE_REORDER_CHK_EN to add the sticky err output for s_last / idle-write protocol checks.
module axis_tile_reorder #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WIDTH  = 4096,
  parameter int MAX_HEIGHT = 2160,
  parameter int BLK        = 4,
  parameter int NBUF       = 2
)(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]  cfg_width,
  input  logic [$clog2(MAX_HEIGHT+1)-1:0] cfg_height,
`ifdef AXIS_TILE_REORDER_CHK_EN
  output logic                            err,
`endif
  output logic                            busy,
  output logic                            done,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            s_last,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser
);
  localparam int WW     = $clog2(MAX_WIDTH+1);
  localparam int HW     = $clog2(MAX_HEIGHT+1);
  localparam int LB     = $clog2(BLK);
  localparam int SW     = $clog2(NBUF);
  localparam int DEPTH  = NBUF*BLK*MAX_WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int STAGES = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic last;
    logic user;
    logic fin;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    tag_t                  tag;
  } beat_t;

  logic [1:0]      state;
  logic [WW-1:0]   w_m1, tiles_m1;
  logic [HW-1:0]   bands_m1;
  logic [NBUF-1:0] valid, set_m, clr_m;
  logic [SW-1:0]   wsel, rsel;
  logic [LB-1:0]   wr_px, wr_trow, rd_row;
  logic [WW-1:0]   wr_tile, rd_col;
  logic [HW-1:0]   rd_band;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic            start_fr, wr_fire, wr_band_end, rd_issue, rd_row_end, rd_band_end, pop;
  logic [STAGES:0] vld_pipe;
  logic [2:0]      occ;
  logic [1:0]      cnt;
  logic            wp, rp;
  beat_t           fifo [2];
  tag_t            rd_tag, rd_tag_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign start_fr    = (state == S_IDLE) & start;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign s_ready     = (state == S_RUN) & ~valid[wsel];
  assign wr_fire     = s_valid & s_ready;
  assign wr_band_end = wr_fire & (wr_px == LB'(BLK-1)) & (wr_trow == LB'(BLK-1)) & (wr_tile == tiles_m1);

  // Issue a read only if the skid can absorb it next cycle: held + in-flight - leaving < 2.
  assign pop         = m_axis_tvalid & m_axis_tready;
  assign occ         = 3'(cnt) + 3'(vld_pipe[1]);
  assign rd_issue    = (state == S_RUN) & valid[rsel] & ((occ - 3'(pop)) < 3'd2);
  assign rd_row_end  = (rd_col == w_m1);
  assign rd_band_end = rd_issue & rd_row_end & (rd_row == LB'(BLK-1));

  assign rd_tag.last = rd_row_end;
  assign rd_tag.user = (rd_band == '0) & (rd_row == '0) & (rd_col == '0);
  assign rd_tag.fin  = rd_row_end & (rd_row == LB'(BLK-1)) & (rd_band == bands_m1);

  assign wr_addr = AW'(wsel)*AW'(BLK*MAX_WIDTH) + AW'(wr_trow)*AW'(MAX_WIDTH)
                 + AW'(wr_tile)*AW'(BLK) + AW'(wr_px);
  assign rd_addr = AW'(rsel)*AW'(BLK*MAX_WIDTH) + AW'(rd_row)*AW'(MAX_WIDTH) + AW'(rd_col);

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (wr_band_end) set_m = NBUF'(1) << wsel;
    if (rd_band_end) clr_m = NBUF'(1) << rsel;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= S_IDLE;
      w_m1     <= '0;
      tiles_m1 <= '0;
      bands_m1 <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state    <= S_RUN;
          w_m1     <= cfg_width - 1'b1;
          tiles_m1 <= (cfg_width >> LB) - 1'b1;
          bands_m1 <= (cfg_height >> LB) - 1'b1;
        end
        S_RUN:  if (pop && fifo[rp].tag.fin) state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end

  // A band fill and a band drain always hit different buffers, so both masks apply together.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      wsel  <= '0;
      rsel  <= '0;
    end else if (start_fr) begin
      valid <= '0;
      wsel  <= '0;
      rsel  <= '0;
    end else begin
      valid <= (valid | set_m) & ~clr_m;
      if (wr_band_end) wsel <= (wsel == SW'(NBUF-1)) ? '0 : wsel + 1'b1;
      if (rd_band_end) rsel <= (rsel == SW'(NBUF-1)) ? '0 : rsel + 1'b1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_px   <= '0;
      wr_trow <= '0;
      wr_tile <= '0;
    end else if (start_fr) begin
      wr_px   <= '0;
      wr_trow <= '0;
      wr_tile <= '0;
    end else if (wr_fire) begin
      if (wr_px == LB'(BLK-1)) begin
        wr_px <= '0;
        if (wr_trow == LB'(BLK-1)) begin
          wr_trow <= '0;
          wr_tile <= (wr_tile == tiles_m1) ? '0 : wr_tile + 1'b1;
        end else wr_trow <= wr_trow + 1'b1;
      end else wr_px <= wr_px + 1'b1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_col  <= '0;
      rd_row  <= '0;
      rd_band <= '0;
    end else if (start_fr) begin
      rd_col  <= '0;
      rd_row  <= '0;
      rd_band <= '0;
    end else if (rd_issue) begin
      if (rd_row_end) begin
        rd_col <= '0;
        if (rd_row == LB'(BLK-1)) begin
          rd_row  <= '0;
          rd_band <= rd_band + 1'b1;
        end else rd_row <= rd_row + 1'b1;
      end else rd_col <= rd_col + 1'b1;
    end

  always_ff @(posedge clk) begin
    if (wr_fire)  mem[wr_addr] <= s_data;
    if (rd_issue) rd_q <= mem[rd_addr];
  end

  assign vld_pipe[0] = rd_issue;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      rd_tag_q           <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (rd_issue) rd_tag_q <= rd_tag;
    end

  // Two-entry skid: the head stays put while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= '0;
    end else begin
      if (vld_pipe[STAGES]) begin
        fifo[wp] <= '{data: rd_q, tag: rd_tag_q};
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(vld_pipe[STAGES]) - 2'(pop);
    end

  assign m_axis_tvalid = (cnt != '0);
  assign m_axis_tdata  = fifo[rp].data;
  assign m_axis_tlast  = fifo[rp].tag.last;
  assign m_axis_tuser  = fifo[rp].tag.user;

`ifdef AXIS_TILE_REORDER_CHK_EN
  localparam int PW = $clog2(MAX_WIDTH*MAX_HEIGHT+1);
  logic [PW-1:0] in_cnt, tot_m1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err    <= 1'b0;
      in_cnt <= '0;
      tot_m1 <= '0;
    end else if (start_fr) begin
      err    <= 1'b0;
      in_cnt <= '0;
      tot_m1 <= PW'(cfg_width) * PW'(cfg_height) - 1'b1;
    end else begin
      if (wr_fire) begin
        in_cnt <= in_cnt + 1'b1;
        if (s_last != (in_cnt == tot_m1)) err <= 1'b1;
      end
      if ((state == S_IDLE) && s_valid) err <= 1'b1;
    end
`else
  logic unused_last;
  assign unused_last = s_last;
`endif
endmodule

// File: tb/tb_axis_tile_reorder.sv
// Directed bench for axis_tile_reorder: raster order, backpressure, single band, reset mid-frame.
module tb_axis_tile_reorder;
  localparam int B = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [4:0]  cfg_width = '0, cfg_height = '0;
  logic        busy, done, s_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic        s_valid = 1'b0, s_last = 1'b0, m_axis_tready = 1'b0;
  logic [31:0] s_data = '0, m_axis_tdata;
`ifdef AXIS_TILE_REORDER_CHK_EN
  logic        err;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } ob_t;

  ob_t q[$];
  int  tests_run = 0, tests_failed = 0;
  int  cyc = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0, done_snap = 0;
  int  rdy_mode = 0;
  bit  prod_to = 0, abort = 0;

  axis_tile_reorder #(.DATA_WIDTH(32), .MAX_WIDTH(16), .MAX_HEIGHT(16), .BLK(B), .NBUF(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
`ifdef AXIS_TILE_REORDER_CHK_EN
    .err(err),
`endif
    .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
  );

  always #5 clk = ~clk;

  // Outputs only change at posedge and tready at posedge+1, so the negedge sees the pending handshake.
  always @(negedge clk) begin
    cyc++;
    if (m_axis_tvalid && m_axis_tready) begin
      q.push_back(ob_t'({m_axis_tdata, m_axis_tlast, m_axis_tuser}));
      last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = 1'b0;
      default: m_axis_tready = ~m_axis_tready;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int first_bad(input int w, input int h);
    for (int i = 0; i < w*h; i++) begin
      if (i >= q.size()) return i;
      if (q[i].d !== 32'((i/w)*16 + i%w) || q[i].l !== (i%w == w-1) || q[i].u !== (i == 0)) return i;
    end
    if (q.size() != w*h) return w*h;
    return -1;
  endfunction

  task automatic start_frame(input int w, input int h);
    @(negedge clk);
    cfg_width  = 5'(w);
    cfg_height = 5'(h);
    start      = 1'b1;
    q.delete();
    done_snap  = done_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic produce(input int w, input int h, input bit rnd, input int last_at);
    int band, r, tile, tr, px, n;
    bit acc;
    prod_to = 0;
    for (int i = 0; i < w*h && !abort; i++) begin
      band = i/(w*B); r = i%(w*B); tile = r/(B*B); tr = (r%(B*B))/B; px = r%B;
      if (rnd) while ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        s_valid = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 32'((band*B + tr)*16 + tile*B + px);
      s_last  = (i == last_at);
      acc = 0; n = 0;
      while (!acc && n < 1000 && !abort) begin
        #1;
        if (s_ready) begin
          acc = 1;
          @(posedge clk);
        end else begin
          @(negedge clk);
          n++;
        end
      end
      if (!acc && !abort) begin
        prod_to = 1;
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_cnt > done_snap) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, s_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got %b want 000000", {busy, done, s_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser});
    end
    tests_run++;
    if (m_axis_tdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_tdata got 0x%0h want 0x0", m_axis_tdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_raster();
    bit ok;
    int bad;
    rdy_mode = 0;
    start_frame(8, 8);
    produce(8, 8, 0, 63);
    wait_done(500, ok);
    tests_run++;
    if (prod_to !== 1'b0) begin tests_failed++; $display("FAIL raster_input_stall got %0b want 0", prod_to); end
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL raster_done_seen got %0b want 1", ok); end
    bad = first_bad(8, 8);
    tests_run++;
    if (bad !== -1) begin tests_failed++; $display("FAIL raster_stream first bad beat %0d (beats %0d) want -1", bad, q.size()); end
    tests_run++;
    if (done_cyc !== last_cyc + 1) begin tests_failed++; $display("FAIL raster_done_timing got %0d want %0d", done_cyc, last_cyc + 1); end
    tests_run++;
    if (done_cnt - done_snap !== 1) begin tests_failed++; $display("FAIL raster_done_count got %0d want 1", done_cnt - done_snap); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL raster_busy_after got %0b want 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    rdy_mode = 1;
    start_frame(8, 8);
    produce(8, 8, 0, 63);
    repeat (5) @(negedge clk);
    tests_run++;
    if (prod_to !== 1'b0) begin tests_failed++; $display("FAIL bp_all_inputs_accepted got stall=%0b want 0", prod_to); end
    tests_run++;
    if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_s_ready_full got %0b want 0", s_ready); end
    tests_run++;
    if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast} !== 3'b110) begin
      tests_failed++;
      $display("FAIL bp_head_flags got %b want 110", {m_axis_tvalid, m_axis_tuser, m_axis_tlast});
    end
    tests_run++;
    if (m_axis_tdata !== 32'h00) begin tests_failed++; $display("FAIL bp_head_data got 0x%0h want 0x0", m_axis_tdata); end
    repeat (10) @(negedge clk);
    tests_run++;
    if (m_axis_tdata !== 32'h00 || q.size() !== 0) begin
      tests_failed++;
      $display("FAIL bp_hold got data 0x%0h beats %0d want 0x0 and 0", m_axis_tdata, q.size());
    end
    rdy_mode = 0;
    wait_done(500, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL bp_done_seen got %0b want 1", ok); end
    bad = first_bad(8, 8);
    tests_run++;
    if (bad !== -1) begin tests_failed++; $display("FAIL bp_stream first bad beat %0d (beats %0d) want -1", bad, q.size()); end
  endtask

  task automatic test_toggle();
    bit ok;
    int bad;
    rdy_mode = 2;
    start_frame(8, 8);
    produce(8, 8, 1, 63);
    wait_done(800, ok);
    rdy_mode = 0;
    tests_run++;
    if (prod_to !== 1'b0) begin tests_failed++; $display("FAIL toggle_input_stall got %0b want 0", prod_to); end
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL toggle_done_seen got %0b want 1", ok); end
    bad = first_bad(8, 8);
    tests_run++;
    if (bad !== -1) begin tests_failed++; $display("FAIL toggle_stream first bad beat %0d (beats %0d) want -1", bad, q.size()); end
  endtask

  task automatic test_single_band();
    bit ok;
    int bad;
    rdy_mode = 0;
    start_frame(4, 4);
    produce(4, 4, 0, 15);
    wait_done(300, ok);
    tests_run++;
    if (ok !== 1'b1 || prod_to !== 1'b0) begin tests_failed++; $display("FAIL single_done got done=%0b stall=%0b want 1 0", ok, prod_to); end
    bad = first_bad(4, 4);
    tests_run++;
    if (bad !== -1) begin tests_failed++; $display("FAIL single_stream first bad beat %0d (beats %0d) want -1", bad, q.size()); end
    tests_run++;
    if (done_cnt - done_snap !== 1) begin tests_failed++; $display("FAIL single_done_count got %0d want 1", done_cnt - done_snap); end
    start_frame(16, 8);
    produce(16, 8, 0, 127);
    wait_done(800, ok);
    tests_run++;
    if (ok !== 1'b1 || prod_to !== 1'b0) begin tests_failed++; $display("FAIL wide_done got done=%0b stall=%0b want 1 0", ok, prod_to); end
    bad = first_bad(16, 8);
    tests_run++;
    if (bad !== -1) begin tests_failed++; $display("FAIL wide_stream first bad beat %0d (beats %0d) want -1", bad, q.size()); end
  endtask

  task automatic test_reset_midframe();
    bit ok, reached;
    int bad;
    rdy_mode = 0;
    reached  = 0;
    abort    = 0;
    start_frame(8, 8);
    fork
      produce(8, 8, 0, 63);
      begin
        for (int k = 0; k < 1000; k++) begin
          @(negedge clk);
          if (q.size() >= 20) begin reached = 1; break; end
        end
        abort = 1;
        @(posedge clk);
        #2 rst_n = 1'b0;
      end
    join
    @(negedge clk);
    tests_run++;
    if (reached !== 1'b1) begin tests_failed++; $display("FAIL rstmid_20_beats got %0b want 1", reached); end
    tests_run++;
    if ({busy, done, s_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 6'b0 || m_axis_tdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstmid_state got %b data 0x%0h want 000000 0x0",
               {busy, done, s_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser}, m_axis_tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    abort = 0;
    start_frame(8, 8);
    produce(8, 8, 0, 63);
    wait_done(500, ok);
    tests_run++;
    if (ok !== 1'b1 || prod_to !== 1'b0) begin tests_failed++; $display("FAIL rstmid_done got done=%0b stall=%0b want 1 0", ok, prod_to); end
    bad = first_bad(8, 8);
    tests_run++;
    if (bad !== -1) begin tests_failed++; $display("FAIL rstmid_stream first bad beat %0d (beats %0d) want -1", bad, q.size()); end
  endtask

`ifdef AXIS_TILE_REORDER_CHK_EN
  task automatic test_chk();
    bit ok;
    rdy_mode = 0;
    start_frame(4, 4);
    produce(4, 4, 0, 10);
    wait_done(300, ok);
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL chk_err_set got %0b want 1", err); end
    repeat (5) @(negedge clk);
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL chk_err_sticky got %0b want 1", err); end
    start_frame(4, 4);
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL chk_err_clear got %0b want 0", err); end
    produce(4, 4, 0, 15);
    wait_done(300, ok);
    tests_run++;
    if (err !== 1'b0 || ok !== 1'b1) begin tests_failed++; $display("FAIL chk_clean_frame got err=%0b done=%0b want 0 1", err, ok); end
  endtask
`endif

  initial begin
    test_reset();
    test_raster();
    test_backpressure();
    test_toggle();
    test_single_band();
    test_reset_midframe();
`ifdef AXIS_TILE_REORDER_CHK_EN
    test_chk();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/axis_tile_reorder.md
Name: axis_tile_reorder

Overview:
- Parametrised successor to the fixed 4-line ping-pong output path in access control.
- Accepts up-sampler output in BLK x BLK tile order. Buffers NBUF bands of BLK rows each.
- Emits raster-order AXI-Stream toward DDR, with row tlast and frame-start tuser.
- Frame size is programmable per frame, with run-time width/height up to the compile-time maximum.

Parameters:
- DATA_WIDTH, 32, pixel word width.
- MAX_WIDTH, 4096, maximum frame width in pixels; RAM depth per row.
- MAX_HEIGHT, 2160, maximum frame height in pixels.
- BLK, 4, tile side in pixels; power of 2, >=2.
- NBUF, 2, number of band buffers; >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_width/cfg_height and begins a frame
- cfg_width  in  clog2(MAX_WIDTH+1)  frame width; multiple of BLK, >=BLK
- cfg_height  in  clog2(MAX_HEIGHT+1)  frame height; multiple of BLK, >=BLK
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last output beat is accepted
- s_valid  in  1  tile-order write valid
- s_ready  out  1  write ready
- s_data  in  DATA_WIDTH  pixel
- s_last  in  1  producer marks last pixel of frame
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  DATA_WIDTH  pixel
- m_axis_tlast  out  1  last pixel of each row
- m_axis_tuser  out  1  first pixel of frame

Behaviour:
- Reset: busy=0, done=0, s_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0. All buffers are invalid; write and read selectors are 0.
- FSM states:
  - IDLE -> RUN on start. W and H are latched; all counters cleared.
  - RUN -> DONE when an output beat with row==H-1 and col==W-1 is accepted.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
  - start outside IDLE is ignored.
  - busy=1 in RUN and DONE.
- Input order within a band:
  - Tiles go left to right.
  - Inside a tile, row-major: BLK consecutive pixels form one tile row, then the next tile row.
- Write address: row = tile-row index (0..BLK-1); col = tile_idx*BLK + pixel index within the tile row.
- A write occurs when s_valid & s_ready. s_ready = RUN & ~valid[wsel].
- After W*BLK writes into buffer wsel: valid[wsel] is set and wsel advances modulo NBUF.
- Read side, when valid[rsel] is set:
  - Read in raster order: row 0..BLK-1, col 0..W-1.
  - Synchronous RAM, one-cycle read latency, feeding a 2-entry output skid.
  - m_axis_tdata, tlast and tuser are stable while tvalid & ~tready.
  - No bubbles under continuous tready after the first beat.
- After the last read address of a band is issued: valid[rsel] clears and rsel advances modulo NBUF.
  - The writer may refill that buffer only after the clear. Pixels still in the skid are unaffected.
- m_axis_tlast=1 when the output col==W-1.
- m_axis_tuser=1 only on the band-0, row-0, col-0 beat.
- Total input beats = total output beats = W*H. Counter widths are sized from MAX_WIDTH*MAX_HEIGHT.
- Simultaneous band-full on the write side and band-clear on the read side of different buffers: both take effect in the same cycle.
- Boundary cases:
  - All buffers valid: s_ready=0 until a clear.
  - No valid buffer: output idles with tvalid=0.
  - W=BLK and H=BLK (single band) must work.
- Reset mid-frame: returns to the reset state immediately; partial data is discarded.

Optional Feature:
- Macro: AXIS_TILE_REORDER_CHK_EN.
- Defined:
  - Adds output err (1 bit, reset 0, sticky until next start).
  - err sets if s_last=1 on an accepted beat other than beat W*H-1.
  - err sets if s_last=0 on accepted beat W*H-1.
  - err sets if s_valid=1 while in IDLE.
- Not defined: port absent, s_last ignored, no check logic.

Test Plan (MAX_WIDTH=16, MAX_HEIGHT=16, BLK=4, NBUF=2):
- start with W=8, H=8; tile-order input with pixel value = row*16+col; tready=1 -> output 0x00..0x07, 0x10..0x17, ..., 0x77 in raster order; tlast on col 7; tuser on first beat only; done pulses once, 1 cycle after the 64th beat.
- Same frame with tready held 0 after the first beat -> s_ready drops after 2 bands written (64 beats accepted, the whole frame); tdata held at 0x00; releasing tready completes the frame unchanged.
- tready toggling 1/0 every cycle with s_valid random -> output sequence identical to the first test; no duplicated or dropped beat.
- W=4, H=4 single band -> 16 raster beats; done pulses; a second start with W=16, H=8 runs correctly without reset.
- Assert rst_n low after 20 output beats, then start W=8, H=8 -> fresh frame; tuser on first beat; no stale data.
- With AXIS_TILE_REORDER_CHK_EN: s_last on beat 10 -> err=1; err stays 1 until the next start clears it.
